// File: rtl/sigmoid_alu_sum_sequencer.sv
// sigmoid_alu_sum_sequencer
// Feeds four signed 8-bit lanes per beat to the external combinational
// 4-way adder and accumulates the returned 10-bit sum over NUM_GROUPS beats.
// The finished pre-activation sum is offered to the sigmoid stage over
// valid/ready.
// Optional feature macro: SIGMOID_SUM_SATURATE_EN (clamp the accumulator on
// overflow instead of wrapping modulo 2^ACC_WIDTH).
//
// Handshake: a beat transfers on any rising edge where in_valid && in_ready;
// the result transfers on any rising edge where out_valid && out_ready.
// in_ready, out_valid and busy decode from state only, so neither valid nor
// ready ever depends combinationally on its partner signal.
module sigmoid_alu_sum_sequencer #(
    parameter int NUM_GROUPS = 196,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    output logic [7:0]           adder_in1,
    output logic [7:0]           adder_in2,
    output logic [7:0]           adder_in3,
    output logic [7:0]           adder_in4,
    input  logic [9:0]           adder_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_GROUPS - 1);

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH-1:0] acc_step;
    logic                        beat_fire;

    // Lanes go straight to the adder in every state; nothing is registered.
    assign adder_in1 = in_data[7:0];
    assign adder_in2 = in_data[15:8];
    assign adder_in3 = in_data[23:16];
    assign adder_in4 = in_data[31:24];

    assign sum_ext   = ACC_WIDTH'($signed(adder_sum));
    assign beat_fire = (state_q == ST_ACCUM) && in_valid;
    assign out_sum   = acc_q;
    assign dbg_state = state_q;

`ifdef SIGMOID_SUM_SATURATE_EN
    logic signed [ACC_WIDTH:0] acc_wide;

    // One extra bit exposes signed overflow; clamp toward the overflowing side.
    always_comb begin
        acc_wide = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(sum_ext);
        if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
            acc_step = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            acc_step = acc_wide[ACC_WIDTH-1:0];
        end
    end
`else
    // Plain two's complement add; overflow wraps modulo 2^ACC_WIDTH.
    always_comb begin
        acc_step = acc_q + sum_ext;
    end
`endif

    // State, accumulator and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    count_d = '0;
                    acc_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (beat_fire) begin
                    acc_d = acc_step;
                    if (count_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here, even alongside out_ready.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/sigmoid_alu_sum_sequencer.md
# sigmoid_ALU_sum_sequencer

Sequences the combinational 4-way adder in the sigmoid ALU over a full neuron fan-in. Accepts a stream of 32-bit beats, each carrying four signed 8-bit products, and routes each beat's lanes to the adder. Accumulates the adder's 10-bit signed sum into a wide accumulator over NUM_GROUPS beats. Presents the final pre-activation sum to the sigmoid stage over a valid/ready handshake.

## Interface
- NUM_GROUPS, 196, beats per accumulation (784 inputs / 4 lanes); must be ≥ 1
- ACC_WIDTH, 18, signed accumulator and result width; must be ≥ 10
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a new accumulation; honoured only in IDLE
- in_valid  in  1  in_data beat valid
- in_ready  out  1  sequencer accepts a beat this cycle
- in_data  in  32  four signed 8-bit lanes: lane0 [7:0], lane1 [15:8], lane2 [23:16], lane3 [31:24]
- adder_in1..adder_in4  out  8 each  lanes 0..3 of in_data, driven to the external 4-way adder
- adder_sum  in  10  signed sum returned by the adder, combinational
- out_valid  out  1  out_sum holds a completed result
- out_ready  in  1  consumer takes the result
- out_sum  out  ACC_WIDTH  signed accumulated result
- busy  out  1  high in ACCUM and DONE

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE → ACCUM on start.
  - On that edge: acc cleared to 0, beat counter cleared to 0.
- ACCUM:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready: acc ← acc + sign_extend(adder_sum) and count ← count + 1.
  - A beat accepted while count == NUM_GROUPS−1 moves the FSM to DONE.
- DONE → IDLE on out_ready.
  - out_valid = 1 throughout DONE; out_sum = acc.
  - acc holds its value until the next start.
- adderIn1..4 are pure combinational pass-through of in_data lanes in every state. The adder is never registered here.
- in_ready = 0 and out_valid = 0 in IDLE.
- start is ignored in ACCUM and DONE, including in the DONE cycle where out_ready is high.
- in_valid is ignored outside ACCUM; no beat is consumed.
- Counter width is clog2(NUM_GROUPS), minimum 1 bit. The counter never wraps mid-accumulation.
- Arithmetic is two's complement, ACC_WIDTH bits. Overflow behaviour is set by Configuration.
- Reset, including mid-ACCUM or mid-DONE: the in-progress sum is discarded and the FSM returns to IDLE immediately.
- Reset values:
  - state IDLE, acc 0, count 0
  - in_ready 0, out_valid 0, out_sum 0, busy 0

## Timing
- start sampled on edge k: in_ready is high from cycle k+1.
- Beat throughput: 1 per cycle. Gaps on in_valid stall accumulation without loss.
- Final beat accepted on edge m: out_valid is high in cycle m+1, with out_sum valid.
- Back-to-back example: start, then in_valid held high. out_valid first asserts NUM_GROUPS+1 cycles after the start edge.
- out_valid & out_ready on edge j: out_valid = 0 and state IDLE in cycle j+1. The earliest new start is sampled on edge j+1.
- out_sum is stable for as long as out_valid is high and out_ready is low.
- in_ready, out_valid and busy are decoded from state only. They carry no combinational path from in_valid or out_ready.

## Configuration
- SIGMOID_SUM_SATURATE_EN defined:
  - Each accumulate step that would overflow clamps acc to 2^(ACC_WIDTH−1)−1 (positive) or −2^(ACC_WIDTH−1) (negative).
  - Clamping is applied per beat; later beats continue from the clamped value.
- Not defined: acc wraps modulo 2^ACC_WIDTH.
- With the default parameters, no overflow is reachable. The worst cases are 196×508 = 99568 and 196×(−512) = −100352. The two builds are therefore identical at defaults.

## Test plan
Unless noted, benches use NUM_GROUPS=4, ACC_WIDTH=12 and an ideal behavioural 4-way adder.
- Reset check: assert rst mid-ACCUM after 2 beats → next cycle in_ready=0, out_valid=0, out_sum=0, busy=0. A following start and 4 beats of 0x01010101 → out_sum=16.
- Positive extreme: start, then 4 beats of 0x7F7F7F7F with in_valid held high → out_valid in the 5th cycle after the start edge; out_sum=2032.
- Negative extreme and stall: start, then 4 beats of 0x80808080 with in_valid low on alternate cycles → out_sum=−2048 (0x800). Only 4 beats are consumed.
- Handshake backpressure: hold out_ready low 3 cycles in DONE, pulse start and in_valid meanwhile → out_sum holds, no beat accepted, start ignored. Raise out_ready → IDLE next cycle.
- Overflow (ACC_WIDTH=11), 4 beats of 0x7F7F7F7F:
  - With SIGMOID_SUM_SATURATE_EN: out_sum=1023.
  - Without: out_sum=−16.
- Mixed lanes: beats 0x7F80FF01 ×4 → per-beat sum 127−128−1+1 = −1; out_sum=−4. Also check adder_in1=0x01 and adder_in4=0x7F on every beat.
